// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: walks an external WORD_W-bit adder
// across NWORDS words, LSW first, chaining the carry through a register.
module mpadd_seq #(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       op_sub,
  input  logic [WORD_W*NWORDS-1:0]   a_in,
  input  logic [WORD_W*NWORDS-1:0]   b_in,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic [WORD_W*NWORDS-1:0]   result,
  output logic                       cout,
  output logic                       overflow,
  output logic [WORD_W-1:0]          adder_a,
  output logic [WORD_W-1:0]          adder_b,
  output logic                       adder_cin,
  input  logic [WORD_W-1:0]          adder_sum,
  input  logic                       adder_cout
);

  localparam int unsigned OpW  = WORD_W * NWORDS;
  localparam int unsigned IdxW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q;
  logic [OpW-1:0]    a_sh_q, b_sh_q, result_q;
  logic              carry_q, cout_q, ovf_q;
  logic              accept, last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        if (idx_q == LastIdx) begin
          last    = 1'b1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operands are held in shift registers so the low word always feeds the adder
  // straight from a flop; after the last word they have shifted out to zero,
  // which keeps the adder inputs quiet outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q  <= a_in;
      b_sh_q  <= b_in ^ {OpW{op_sub}};
      carry_q <= op_sub;
      idx_q   <= '0;
    end else if (state_q == StRun) begin
      result_q[idx_q*WORD_W +: WORD_W] <= adder_sum;
      a_sh_q <= a_sh_q >> WORD_W;
      b_sh_q <= b_sh_q >> WORD_W;
      if (last) begin
        carry_q <= 1'b0;
        idx_q   <= '0;
        cout_q  <= adder_cout;
        ovf_q   <= (a_sh_q[WORD_W-1] == b_sh_q[WORD_W-1]) &&
                   (adder_sum[WORD_W-1] != a_sh_q[WORD_W-1]);
      end else begin
        carry_q <= adder_cout;
        idx_q   <= idx_q + 1'b1;
      end
    end
  end

  assign ready     = (state_q == StIdle);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign adder_a   = a_sh_q[WORD_W-1:0];
  assign adder_b   = b_sh_q[WORD_W-1:0];
  assign adder_cin = carry_q;

endmodule
